// File: rtl/connection_block_pkg.sv
// Geometry of the connection-block configuration word and the track rotation arithmetic.
// Word layout, LSB first: clb0 input fields, clb0 output fields, clb1 input fields, clb1 output fields.
package connection_block_pkg;

    // Selectable sources of one CLB input: tracks, globals and, optionally, the neighbour's outputs.
    function automatic int cb_in_fw(input int ws, input int wd, input int wg,
                                    input int clbx, input int nout_other);
        return ws + wd + wg + clbx * nout_other;
    endfunction

    function automatic int cb_out_fw(input int os, input int od);
        return os + od;
    endfunction

    function automatic int cb_out0_base(input int in0, input int fi1);
        return in0 * fi1;
    endfunction

    function automatic int cb_in1_base(input int in0, input int fi1,
                                       input int out0, input int ofw);
        return cb_out0_base(in0, fi1) + out0 * ofw;
    endfunction

    function automatic int cb_out1_base(input int in0, input int fi1, input int out0,
                                        input int ofw, input int in1, input int fi0);
        return cb_in1_base(in0, fi1, out0, ofw) + in1 * fi0;
    endfunction

    function automatic int cb_ncfg(input int in0, input int fi1, input int out0, input int ofw,
                                   input int in1, input int fi0, input int out1);
        return cb_out1_base(in0, fi1, out0, ofw, in1, fi0) + out1 * ofw;
    endfunction

    // Drivers are numbered globally (clb0 outputs first) so neighbouring outputs land on staggered tracks.
    function automatic int cb_track_idx(input int j, input int g, input int per,
                                        input int bias, input int ndrv, input int w);
        return (j + g * per + bias * per * ndrv) % w;
    endfunction

endpackage

// File: rtl/connection_block_input_mux.sv
// One CLB input: AND-OR of the configured source bits, forced low while the block is disabled.
// Purely combinational; no flow control.
module cb_input_mux #(
    parameter int NSRC = 18
) (
    input  logic            en,
    input  logic [NSRC-1:0] sel,
    input  logic [NSRC-1:0] src,
    output logic            y
);

    assign y = en & (|(sel & src));

endmodule

// File: rtl/connection_block.sv
// Static-configured connection block between two CLBs and a routing channel; tracks and carries pass through.
// Routing is combinational; only the enable flop is clocked, so reset takes effect one edge later.
module connection_block
    import connection_block_pkg::*;
#(
    parameter int WS         = 7,
    parameter int WD         = 6,
    parameter int WG         = 3,
    parameter int CLBIN      = 6,
    parameter int CLBIN0     = 2,
    parameter int CLBIN1     = 2,
    parameter int CLBOUT     = 2,
    parameter int CLBOUT0    = 2,
    parameter int CLBOUT1    = 2,
    parameter int CARRY      = 1,
    parameter int CLBOS      = 2,
    parameter int CLBOD      = 2,
    parameter int CLBOS_BIAS = 1,
    parameter int CLBOD_BIAS = 1,
    parameter int CLBX       = 1,
    localparam int FI0  = cb_in_fw(WS, WD, WG, CLBX, CLBOUT0),
    localparam int FI1  = cb_in_fw(WS, WD, WG, CLBX, CLBOUT1),
    localparam int OFW  = cb_out_fw(CLBOS, CLBOD),
    localparam int NCFG = cb_ncfg(CLBIN0, FI1, CLBOUT0, OFW, CLBIN1, FI0, CLBOUT1)
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [WS-1:0]     single0,
    inout  wire  [WS-1:0]     single1,
    inout  wire  [WD-1:0]     double0,
    inout  wire  [WD-1:0]     double1,
    input  logic [WG-1:0]     global0,
    input  logic [CLBOUT-1:0] clb0_output,
    input  logic [CLBOUT-1:0] clb1_output,
    input  logic [CARRY-1:0]  clb0_cout,
    input  logic [CARRY-1:0]  clb1_cout,
    output logic [CLBIN-1:0]  clb0_input,
    output logic [CLBIN-1:0]  clb1_input,
    output logic [CARRY-1:0]  clb0_cin,
    output logic [CARRY-1:0]  clb1_cin,
    input  logic [NCFG-1:0]   c
);

    localparam int OB0  = cb_out0_base(CLBIN0, FI1);
    localparam int IB1  = cb_in1_base(CLBIN0, FI1, CLBOUT0, OFW);
    localparam int OB1  = cb_out1_base(CLBIN0, FI1, CLBOUT0, OFW, CLBIN1, FI0);
    localparam int NDRV = CLBOUT0 + CLBOUT1;
    localparam int NSD  = NDRV * CLBOS;
    localparam int NDD  = NDRV * CLBOD;

    logic en;

    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
        end else begin
            en <= 1'b1;
        end
    end

    // The carry chain ignores configuration and reset entirely.
    assign clb0_cin = clb1_cout;
    assign clb1_cin = clb0_cout;

    logic [FI1-1:0] src0;
    logic [FI0-1:0] src1;

    if (CLBX != 0) begin : g_direct
        assign src0 = {clb1_output[CLBOUT1-1:0], global0, double0, single0};
        assign src1 = {clb0_output[CLBOUT0-1:0], global0, double0, single0};
    end else begin : g_no_direct
        assign src0 = {global0, double0, single0};
        assign src1 = {global0, double0, single0};
    end

    for (genvar i = 0; i < CLBIN; i++) begin : g_in0
        if (i < CLBIN0) begin : g_mux
            cb_input_mux #(.NSRC(FI1)) u_mux (
                .en  (en),
                .sel (c[i*FI1 +: FI1]),
                .src (src0),
                .y   (clb0_input[i])
            );
        end else begin : g_tie
            assign clb0_input[i] = 1'b0;
        end
    end

    for (genvar i = 0; i < CLBIN; i++) begin : g_in1
        if (i < CLBIN1) begin : g_mux
            cb_input_mux #(.NSRC(FI0)) u_mux (
                .en  (en),
                .sel (c[IB1 + i*FI0 +: FI0]),
                .src (src1),
                .y   (clb1_input[i])
            );
        end else begin : g_tie
            assign clb1_input[i] = 1'b0;
        end
    end

    logic [NDRV-1:0] drv_out;
    logic [NSD-1:0]  s_on;
    logic [NDD-1:0]  d_on;

    assign drv_out = {clb1_output[CLBOUT1-1:0], clb0_output[CLBOUT0-1:0]};

    for (genvar g = 0; g < NDRV; g++) begin : g_drv
        localparam int FB = (g < CLBOUT0) ? OB0 + g * OFW : OB1 + (g - CLBOUT0) * OFW;
        for (genvar j = 0; j < CLBOS; j++) begin : g_s
            assign s_on[g*CLBOS + j] = en & c[FB + j];
        end
        for (genvar j = 0; j < CLBOD; j++) begin : g_d
            assign d_on[g*CLBOD + j] = en & c[FB + CLBOS + j];
        end
    end

    // Per track, collect every driver whose rotated index lands on it.
    logic [WS-1:0][NSD-1:0] s_hit;
    logic [WS-1:0][NSD-1:0] s_hv;
    logic [WD-1:0][NDD-1:0] d_hit;
    logic [WD-1:0][NDD-1:0] d_hv;

    for (genvar t = 0; t < WS; t++) begin : g_strk
        for (genvar k = 0; k < NSD; k++) begin : g_src
            localparam int G = k / CLBOS;
            localparam int T = cb_track_idx(k % CLBOS, G, CLBOS, CLBOS_BIAS, NDRV, WS);
            if (T == t) begin : g_hit
                assign s_hit[t][k] = s_on[k];
                assign s_hv[t][k]  = s_on[k] & drv_out[G];
            end else begin : g_miss
                assign s_hit[t][k] = 1'b0;
                assign s_hv[t][k]  = 1'b0;
            end
        end
        assign single0[t] = (|s_hit[t]) ? (|s_hv[t]) : 1'bz;
        assign single1[t] = (|s_hit[t]) ? (|s_hv[t]) : 1'bz;
    end

    // Only the lower half of the double tracks starts a segment here.
    for (genvar t = 0; t < WD; t++) begin : g_dtrk
        for (genvar k = 0; k < NDD; k++) begin : g_src
            localparam int G = k / CLBOD;
            localparam int T = cb_track_idx(k % CLBOD, G, CLBOD, CLBOD_BIAS, NDRV, WD / 2);
            if (T == t) begin : g_hit
                assign d_hit[t][k] = d_on[k];
                assign d_hv[t][k]  = d_on[k] & drv_out[G];
            end else begin : g_miss
                assign d_hit[t][k] = 1'b0;
                assign d_hv[t][k]  = 1'b0;
            end
        end
        assign double0[t] = (|d_hit[t]) ? (|d_hv[t]) : 1'bz;
        assign double1[t] = (|d_hit[t]) ? (|d_hv[t]) : 1'bz;
    end

endmodule

// File: tb/tb_connection_block.sv
// Scoreboarded random/directed bench for connection_block at default parameters.
// Both sides of each track are one physical net in the fabric, so the bench ties them to a single wire.
module tb_connection_block;

    localparam int WS     = 7;
    localparam int WD     = 6;
    localparam int WG     = 3;
    localparam int CLBIN  = 6;
    localparam int CLBOUT = 2;
    localparam int CARRY  = 1;
    localparam int NCFG   = 88;
    localparam int FIW    = WS + WD + WG + CLBOUT;
    localparam int OFW    = 4;
    localparam int IN1B   = 2 * FIW + 2 * OFW;
    localparam int OUT1B  = IN1B + 2 * FIW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCFG-1:0]   c;
    logic [WG-1:0]     global0;
    logic [CLBOUT-1:0] clb0_output, clb1_output;
    logic [CARRY-1:0]  clb0_cout, clb1_cout;
    logic [CLBIN-1:0]  clb0_input, clb1_input;
    logic [CARRY-1:0]  clb0_cin, clb1_cin;
    wire  [WS-1:0]     s_net;
    wire  [WD-1:0]     d_net;
    logic [WS-1:0]     s_drv, s_oe;
    logic [WD-1:0]     d_drv, d_oe;

    for (genvar k = 0; k < WS; k++) begin : g_sext
        assign s_net[k] = s_oe[k] ? s_drv[k] : 1'bz;
    end
    for (genvar k = 0; k < WD; k++) begin : g_dext
        assign d_net[k] = d_oe[k] ? d_drv[k] : 1'bz;
    end

    always #5 clk = ~clk;

    connection_block dut (
        .clk         (clk),
        .rst         (rst),
        .single0     (s_net),
        .single1     (s_net),
        .double0     (d_net),
        .double1     (d_net),
        .global0     (global0),
        .clb0_output (clb0_output),
        .clb1_output (clb1_output),
        .clb0_cout   (clb0_cout),
        .clb1_cout   (clb1_cout),
        .clb0_input  (clb0_input),
        .clb1_input  (clb1_input),
        .clb0_cin    (clb0_cin),
        .clb1_cin    (clb1_cin),
        .c           (c)
    );

    typedef struct {
        string            nm;
        logic [CLBIN-1:0] in0;
        logic [CLBIN-1:0] in1;
        logic [WS-1:0]    s_m;
        logic [WS-1:0]    s_v;
        logic [WD-1:0]    d_m;
        logic [WD-1:0]    d_v;
        logic [CARRY-1:0] ci0;
        logic [CARRY-1:0] ci1;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic m_en;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: evaluates the routing rules directly from the configuration word.
    function automatic exp_t model(input string nm);
        exp_t e;
        int   base, t;
        logic v, o;
        e.nm  = nm;
        e.in0 = '0;
        e.in1 = '0;
        e.s_m = s_oe;
        e.s_v = s_drv & s_oe;
        e.d_m = d_oe;
        e.d_v = d_drv & d_oe;
        e.ci0 = clb1_cout;
        e.ci1 = clb0_cout;
        if (m_en) begin
            for (int a = 0; a < 2; a++) begin
                for (int i = 0; i < 2; i++) begin
                    base = (a == 0) ? i * FIW : IN1B + i * FIW;
                    for (int b = 0; b < FIW; b++) begin
                        if (c[base + b]) begin
                            if (b < WS)                v = s_drv[b];
                            else if (b < WS + WD)      v = d_drv[b - WS];
                            else if (b < WS + WD + WG) v = global0[b - WS - WD];
                            else if (a == 0)           v = clb1_output[b - WS - WD - WG];
                            else                       v = clb0_output[b - WS - WD - WG];
                            if (v) begin
                                if (a == 0) e.in0[i] = 1'b1;
                                else        e.in1[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                base = (g < 2) ? 2 * FIW + g * OFW : OUT1B + (g - 2) * OFW;
                o    = (g < 2) ? clb0_output[g] : clb1_output[g - 2];
                for (int j = 0; j < 2; j++) begin
                    if (c[base + j]) begin
                        t = (j + g * 2 + 1 * 2 * 4) % WS;
                        e.s_m[t] = 1'b1;
                        e.s_v[t] = o;
                    end
                    if (c[base + 2 + j]) begin
                        t = (j + g * 2 + 1 * 2 * 4) % (WD / 2);
                        e.d_m[t] = 1'b1;
                        e.d_v[t] = o;
                    end
                end
            end
        end
        return e;
    endfunction

    // Expectation for the stimulus now applied; checked at the following falling edge.
    task automatic step(input string nm);
        q.push_back(model(nm));
        @(posedge clk);
        m_en = !rst;
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, " clb0_input"}, 16'(clb0_input), 16'(e.in0));
                chk({e.nm, " clb1_input"}, 16'(clb1_input), 16'(e.in1));
                chk({e.nm, " single"}, 16'(s_net & e.s_m), 16'(e.s_v));
                chk({e.nm, " double"}, 16'(d_net & e.d_m), 16'(e.d_v));
                chk({e.nm, " clb0_cin"}, 16'(clb0_cin), 16'(e.ci0));
                chk({e.nm, " clb1_cin"}, 16'(clb1_cin), 16'(e.ci1));
            end
        end
    end

    initial begin
        int f;
        int fb;
        rst = 1'b1; c = '1;
        s_drv = '0; s_oe = '1; d_drv = '0; d_oe = '1;
        global0 = '1; clb0_output = '1; clb1_output = '1;
        clb0_cout = 1'b1; clb1_cout = 1'b0;
        m_en = 1'b0;
        @(posedge clk);
        m_en = !rst;
        #1;

        // Held in reset with everything configured: block must stay silent.
        step("reset");
        clb0_cout = 1'b0; clb1_cout = 1'b1;
        step("reset_carry");
        rst = 1'b0; c = '0;
        step("rst_release");

        global0 = '0; clb0_output = '0; clb1_output = '0;
        c = '0; c[3] = 1'b1; s_drv = 7'b0001000;
        step("sel_single");
        s_drv = 7'b1110111;
        step("sel_single_off");
        c = '0; c[14] = 1'b1; s_drv = '0; global0 = 3'b010;
        step("sel_global");
        c = '0; c[17] = 1'b1; global0 = '0; clb1_output = 2'b10;
        step("sel_clb");

        s_oe = '0; d_oe = '0; clb1_output = '0;
        c = '0; c[36] = 1'b1; clb0_output = 2'b01;
        step("drv_single1");
        c = '0; c[39] = 1'b1;
        step("drv_double0");
        c = '0; c[80] = 1'b1; clb1_output = 2'b01;
        step("drv_single5_hi");
        clb1_output = 2'b10;
        step("drv_single5_lo");
        c = '0; c[85] = 1'b1; clb1_output = 2'b10;
        step("drv_single1_clb1");

        c = '0;
        for (int n = 0; n < 100; n++) begin
            rst         = 1'($urandom_range(0, 1));
            s_drv       = WS'($urandom);
            s_oe        = WS'($urandom);
            d_drv       = WD'($urandom);
            d_oe        = WD'($urandom);
            global0     = WG'($urandom);
            clb0_output = CLBOUT'($urandom);
            clb1_output = CLBOUT'($urandom);
            clb0_cout   = CARRY'($urandom);
            clb1_cout   = CARRY'($urandom);
            step("pass");
        end
        rst = 1'b0;
        step("settle");

        for (int n = 0; n < 10; n++) begin
            c = '0; s_oe = '1; d_oe = '1;
            s_drv = WS'($urandom); d_drv = WD'($urandom); global0 = WG'($urandom);
            clb0_output = CLBOUT'($urandom); clb1_output = CLBOUT'($urandom);
            for (int k = 0; k < 4; k++) begin
                fb = (k < 2) ? k * FIW : IN1B + (k - 2) * FIW;
                c[fb + $urandom_range(0, FIW - 1)] = 1'b1;
            end
            step("sweep_in");
        end

        for (int n = 0; n < 10; n++) begin
            c = '0; s_oe = '0; d_oe = '0;
            clb0_output = CLBOUT'($urandom); clb1_output = CLBOUT'($urandom);
            f  = $urandom_range(0, 3);
            fb = (f < 2) ? 2 * FIW + f * OFW : OUT1B + (f - 2) * OFW;
            c[fb + $urandom_range(0, OFW - 1)] = 1'b1;
            step("sweep_out");
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
